multicycle_seq_ctrl: RTL
========================

// Module: multicycle_seq_ctrl
// PURPOSE
//  Parametrised multi-cycle instruction sequencer: Fetch/Decode/Mem/WriteBack/UpdatePC with halt/resume.
//  Adds a MEM stage, per-stage watchdog trap, registered glitch-free strobes and a retired-instruction counter.
//  Sits between datapath stage units (fetch, decode, LSU, regfile WB, PC) and the top-level core.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles in one stage without done before TRAP; 0 disables watchdog
//  TO_W            8    watchdog counter width; must hold TIMEOUT_CYCLES
//  CNT_W           32   retired-instruction counter width
// PORTS
//  clk             in   1      rising-edge clock
//  rst_n           in   1      async active-low reset
//  halt_req_i      in   1      request halt; level
//  resume_i        in   1      leave HALT/TRAP; level
//  fetch_done_i    in   1      fetch unit done
//  decode_done_i   in   1      decode done; qualifiers below valid when high
//  branch_taken_i  in   1      decoded instr redirects PC, no MEM/WB
//  mem_read_i      in   1      decoded instr is load
//  mem_write_i     in   1      decoded instr is store
//  reg_write_i     in   1      decoded instr writes regfile
//  mem_done_i      in   1      LSU done
//  wb_done_i       in   1      writeback done
//  pc_done_i       in   1      PC updated
//  start_fetch_o   out  1      high while state==FETCH
//  start_decode_o  out  1      high while state==DECODE
//  start_mem_o     out  1      high while state==MEM
//  start_wb_o      out  1      high while state==WB
//  pc_write_o      out  1      high while state==UPD_PC
//  halted_o        out  1      high while state==HALT
//  trap_o          out  1      high while state==TRAP
//  state_o         out  3      current state encoding
//  retired_o       out  CNT_W  instructions retired
// BEHAVIOUR
//  - One clock (clk); reset is asynchronous, active-low (rst_n). Reset: state=FETCH, start_fetch_o=1,
//    all other strobes/halted_o/trap_o=0, retired_o=0, watchdog=0. Fetch requested 1st cycle after release.
//  - All outputs are flops loaded from next-state decode: no combinational paths input->output.
//  - Handshake: strobe held high in its state; done sampled at posedge -> next state same edge,
//    strobe drops that edge (1-cycle min per stage). done while not in matching state is ignored.
//  - Transitions (halt_req_i checked first in every active state; halt beats done same cycle):
//    FETCH  --fetch_done--> DECODE
//    DECODE --decode_done--> UPD_PC if branch_taken; else MEM if mem_read|mem_write;
//                            else WB if reg_write; else UPD_PC. branch_taken outranks mem flags.
//    MEM    --mem_done--> WB if load (mem_read latched at decode_done); UPD_PC if store
//    WB     --wb_done--> UPD_PC
//    UPD_PC --pc_done--> FETCH; retired_o += 1 same edge, wraps mod 2^CNT_W
//    any active --halt_req--> HALT; in-flight instr discarded, retired_o unchanged
//    HALT   --resume & !halt_req--> FETCH (resume with halt_req high: stay HALT)
//    TRAP   --resume--> FETCH; halt_req in TRAP -> HALT
//  - Load/store flags latched at decode_done; later input changes ignored until next DECODE.
//  - Watchdog: cleared on every state change; counts each cycle in active state without its done;
//    when count==TIMEOUT_CYCLES-1 and done low -> TRAP next edge. done on that same cycle wins.
//    Not running in HALT/TRAP. TIMEOUT_CYCLES=0: never traps.
//  - Illegal state encoding -> FETCH next edge.
//  - state_o: FETCH=0 DECODE=1 MEM=2 WB=3 UPD_PC=4 HALT=5 TRAP=6.
// STRUCTURE
//  - seq_ctrl_pkg: state localparams (encodings above), default TIMEOUT_CYCLES.
//  - Sub-module stage_watchdog (clr, en, done -> expire), params TIMEOUT_CYCLES/TO_W.
//  - FSM, strobe decode flops and retire counter in this module.
// TESTING
//  1 Reset then ALU instr (reg_write=1): dones each 1 cycle after strobe -> F,D,WB,UPD_PC,F; retired_o=1.
//  2 Load then store: load visits MEM->WB; store MEM->UPD_PC with start_wb_o never high; retired_o=2.
//  3 branch_taken=1 with mem_write=1 at decode_done -> UPD_PC directly, start_mem_o never high.
//  4 halt_req and wb_done same cycle -> HALT, retired_o unchanged; resume with halt_req high stays
//    HALT; drop halt_req -> FETCH next edge.
//  5 TIMEOUT_CYCLES=4, mem_done held low -> trap_o high 4 cycles after MEM entry; done on 4th cycle
//    instead -> no trap. resume -> FETCH.
//  6 rst_n low mid-WB (async, off-edge) -> outputs reset immediately; retired_o=0; wrap at CNT_W=4 after 16.

Source files
------------

// File: rtl/multicycle_seq_ctrl_pkg.sv
// Shared types for the multi-cycle sequencer: state encodings, strobe bundle and default limits.
package seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_MEM    = 3'd2,
    ST_WB     = 3'd3,
    ST_UPD_PC = 3'd4,
    ST_HALT   = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

  typedef struct packed {
    logic fetch;
    logic decode;
    logic mem;
    logic wb;
    logic pc_write;
    logic halted;
    logic trap;
  } strobe_t;

  localparam strobe_t RESET_STROBE = '{fetch: 1'b1, default: 1'b0};

  // Exactly one strobe per legal state; an illegal encoding drives nothing.
  function automatic strobe_t strobe_decode(input state_e s);
    strobe_t st;
    st = '0;
    case (s)
      ST_FETCH:  st.fetch    = 1'b1;
      ST_DECODE: st.decode   = 1'b1;
      ST_MEM:    st.mem      = 1'b1;
      ST_WB:     st.wb       = 1'b1;
      ST_UPD_PC: st.pc_write = 1'b1;
      ST_HALT:   st.halted   = 1'b1;
      ST_TRAP:   st.trap     = 1'b1;
      default:   st          = '0;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/multicycle_seq_ctrl_watchdog.sv
// Per-stage watchdog: counts cycles spent in an active stage without its done, flags expiry.
module stage_watchdog
  import seq_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned TO_W           = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic done,
  output logic expire
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !done) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  // A done arriving on the final allowed cycle suppresses expiry.
  assign expire = (TIMEOUT_CYCLES != 0) && en && !done && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_seq_ctrl.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/MEM/WB/UPD_PC with halt, resume and watchdog trap.
module multicycle_seq_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned TO_W           = 8,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             halt_req_i,
  input  logic             resume_i,
  input  logic             fetch_done_i,
  input  logic             decode_done_i,
  input  logic             branch_taken_i,
  input  logic             mem_read_i,
  input  logic             mem_write_i,
  input  logic             reg_write_i,
  input  logic             mem_done_i,
  input  logic             wb_done_i,
  input  logic             pc_done_i,
  output logic             start_fetch_o,
  output logic             start_decode_o,
  output logic             start_mem_o,
  output logic             start_wb_o,
  output logic             pc_write_o,
  output logic             halted_o,
  output logic             trap_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired_o
);

  // Handshake: a stage strobe stays high for the whole stage; its done is sampled on
  // the rising edge, which moves the FSM and drops the strobe on that same edge.
  // A done seen outside its own stage has no effect.

  state_e           state_q, state_d;
  logic             is_load_q, is_load_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  strobe_t          strobe_q, strobe_d;
  logic             stage_done;
  logic             active;
  logic             wd_expire;

  always_comb begin
    stage_done = 1'b0;
    active     = 1'b1;
    case (state_q)
      ST_FETCH:  stage_done = fetch_done_i;
      ST_DECODE: stage_done = decode_done_i;
      ST_MEM:    stage_done = mem_done_i;
      ST_WB:     stage_done = wb_done_i;
      ST_UPD_PC: stage_done = pc_done_i;
      default:   active     = 1'b0;
    endcase
  end

  stage_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_watchdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_d != state_q),
    .en    (active),
    .done  (stage_done),
    .expire(wd_expire)
  );

  always_comb begin
    state_d   = state_q;
    is_load_d = is_load_q;
    retired_d = retired_q;
    case (state_q)
      ST_FETCH: if (fetch_done_i) state_d = ST_DECODE;
      ST_DECODE: begin
        if (decode_done_i) begin
          is_load_d = mem_read_i;
          if (branch_taken_i)                state_d = ST_UPD_PC;
          else if (mem_read_i || mem_write_i) state_d = ST_MEM;
          else if (reg_write_i)              state_d = ST_WB;
          else                               state_d = ST_UPD_PC;
        end
      end
      ST_MEM: if (mem_done_i) state_d = is_load_q ? ST_WB : ST_UPD_PC;
      ST_WB:  if (wb_done_i) state_d = ST_UPD_PC;
      ST_UPD_PC: begin
        if (pc_done_i) begin
          state_d   = ST_FETCH;
          retired_d = retired_q + CNT_W'(1);
        end
      end
      ST_HALT: if (resume_i && !halt_req_i) state_d = ST_FETCH;
      ST_TRAP: begin
        if (halt_req_i)    state_d = ST_HALT;
        else if (resume_i) state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
    // Halt discards the in-flight instruction, even when its done arrives the same cycle.
    if (active) begin
      if (halt_req_i) begin
        state_d   = ST_HALT;
        retired_d = retired_q;
      end else if (wd_expire) begin
        state_d = ST_TRAP;
      end
    end
    strobe_d = strobe_decode(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      is_load_q <= 1'b0;
      retired_q <= '0;
      strobe_q  <= RESET_STROBE;
    end else begin
      state_q   <= state_d;
      is_load_q <= is_load_d;
      retired_q <= retired_d;
      strobe_q  <= strobe_d;
    end
  end

  assign start_fetch_o  = strobe_q.fetch;
  assign start_decode_o = strobe_q.decode;
  assign start_mem_o    = strobe_q.mem;
  assign start_wb_o     = strobe_q.wb;
  assign pc_write_o     = strobe_q.pc_write;
  assign halted_o       = strobe_q.halted;
  assign trap_o         = strobe_q.trap;
  assign state_o        = state_q;
  assign retired_o      = retired_q;

endmodule
